score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Scoreboard stage directly downstream of the puck/ball physics blocks.
- Turns their per-frame `hit_target` / `hit_floor` level flags into one-point-per-event BCD scores for two players.
- Runs a serve hold-off and win detection, and drives the four seven-segment digit nibbles consumed by the HexDriver instances.
- Clocked on the 50 MHz `Clk`. `frame_clk` (VGA vsync) is an input that gets synchronised, not used as a clock.

Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..99.
- HOLDOFF_FRAMES, 60: frame ticks after a point during which new hits are ignored; legal range 1..255.
- SYNC_STAGES, 2: flip-flop synchroniser depth for `frame_clk`, `hit_target`, `hit_floor`.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  VGA vertical sync; rising edge after sync = one frame tick
- hit_target  in  1  level from puck; rising edge = point to player 1
- hit_floor  in  1  level from puck; rising edge = point to player 2
- game_active  in  1  high while Game1Screen or Game2Screen is shown
- clear_scores  in  1  single-Clk pulse; zero scores, return to IDLE
- p1_ones  out  4  player-1 BCD ones digit
- p1_tens  out  4  player-1 BCD tens digit
- p2_ones  out  4  player-2 BCD ones digit
- p2_tens  out  4  player-2 BCD tens digit
- point_pulse  out  1  one-Clk pulse when a point is awarded
- winner  out  2  00 none, 01 player 1, 10 player 2
- game_over  out  1  high in OVER state

Behaviour:
- **Reset**
  - All digits 0, `point_pulse` 0, `winner` 00, `game_over` 0.
  - State IDLE, hold-off counter 0, synchronisers cleared.
- **Synchronisation and sampling**
  - `frame_clk`, `hit_target` and `hit_floor` each pass through SYNC_STAGES flops.
  - `frame_tick` = one-Clk pulse on the synchronised `frame_clk` rising edge.
  - The hit flags are sampled only on `frame_tick`; the previous sample is stored.
  - `evt1` = sampled `hit_target` rising versus the previous sample; `evt2` likewise for `hit_floor`.
  - A flag held high for many frames yields exactly one event.
- **State machine**
  - IDLE:
    - `game_active`=1 goes to PLAY.
    - Events are ignored.
  - PLAY:
    - `evt1` xor `evt2` on a tick: increment that player's score, pulse `point_pulse` on the following Clk, load hold-off = HOLDOFF_FRAMES, go to HOLD.
    - `evt1` and `evt2` together on the same tick: a let. No score, no pulse, no hold-off, stay in PLAY.
    - `game_active`=0 goes to IDLE; scores are kept.
  - HOLD:
    - Counter decrements on each `frame_tick`.
    - Events are ignored, but the edge-detect history still updates, so a flag still high at expiry does not score.
    - Counter reaching 0 goes to PLAY.
    - `game_active`=0 goes to IDLE.
  - OVER:
    - Entered when the incremented score reaches the win threshold. Entry is decided in the same cycle as the increment; HOLD is skipped.
    - `game_over`=1 and `winner` set.
    - Only `clear_scores` or Reset leaves OVER.
- **`clear_scores`**
  - Valid in any state and takes priority over a same-cycle event.
  - Zeroes digits, `winner`, `game_over` and the hold-off counter; goes to IDLE.
- **BCD increment**
  - Ones 9→0 with tens+1.
  - At 99 the score saturates and never wraps.
- **Threshold compare**
  - The win check is done on the binary-equivalent value tens*10+ones ≥ WIN_SCORE.
- **Reset mid-hold**
  - Reset returns everything to reset values immediately; it is asynchronous.

Optional Feature:
- Macro: `SCORE_WIN_BY_TWO_EN`.
- Defined:
  - A player wins only when score ≥ WIN_SCORE and score − other score ≥ 2.
  - Otherwise play continues through HOLD, with saturation at 99.
  - If both scores reach 99 with no 2-point lead, the next point still cannot win. Scores stay at 99, and `game_over` is asserted with `winner`=11 (draw).
- Undefined: the first player to reach WIN_SCORE wins, and the encoding 11 is never produced.

Decomposition:
- Package `score_pkg`:
  - typedef `bcd2_t` (struct of tens, ones; 4 bits each).
  - Enum `score_state_t` {IDLE, PLAY, HOLD, OVER}.
  - Constants WINNER_NONE/P1/P2/DRAW.
  - Function `bcd2_to_int`.
- Sub-module `bcd2_counter`:
  - Inputs: Clk, Reset, clear, inc.
  - Output: two BCD nibbles, saturating at 99.
  - Instantiated once per player.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset → all digits 0, `winner`=00. Raise `game_active`, hold `hit_target` high for 5 frames → `p1_ones`=1, exactly one `point_pulse`, state HOLD.
- With HOLDOFF_FRAMES=3, a point then `hit_floor` pulsed in frames 1–2 after it → no score. Pulse it again in frame 5 → `p2_ones`=1.
- `hit_target` and `hit_floor` rising in the same frame → no change, no `point_pulse`.
- WIN_SCORE=12, twelve separated `hit_target` events:
  - after the tenth: `p1_tens`=1, `p1_ones`=0;
  - after the twelfth: `game_over`=1, `winner`=01;
  - further hits → no change.
- `clear_scores` asserted in OVER in the same cycle as an event → digits 0, `winner`=00, state IDLE.
- With `SCORE_WIN_BY_TWO_EN`, WIN_SCORE=3, scores 3–3 then player 2 scores → 3–4, no win. Player 2 scores again → 3–5, `winner`=10.

Source files
------------

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//   Shared types and helpers for the score_keeper block.
//   - bcd2_t        : two-digit BCD score (tens, ones)
//   - score_state_t : game state machine encoding
//   - WINNER_*      : encodings driven on the winner output
//   - bcd2_to_int   : BCD pair to binary value, used for threshold compares
//   - bcd2_inc_sat  : BCD increment that saturates at 99
// -----------------------------------------------------------------------------
package score_pkg;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } score_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam bcd2_t BCD2_ZERO = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t BCD2_MAX  = '{tens: 4'd9, ones: 4'd9};

  function automatic int unsigned bcd2_to_int(input bcd2_t v);
    return (32'(v.tens) * 32'd10) + 32'(v.ones);
  endfunction

  function automatic bcd2_t bcd2_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v == BCD2_MAX) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage : score_pkg

// File: rtl/bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
//   Two-digit BCD up-counter for one player's score. Saturates at 99.
//   Ports:
//     Clk    in  system clock
//     Reset  in  asynchronous, active-high reset (count -> 00)
//     clear  in  synchronous clear to 00, wins over inc
//     inc    in  add one point this cycle
//     tens   out BCD tens digit
//     ones   out BCD ones digit
// -----------------------------------------------------------------------------
module bcd2_counter
  import score_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd2_t count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    count_d = count_q;
    if (clear) begin
      count_d = BCD2_ZERO;
    end else if (inc) begin
      count_d = bcd2_inc_sat(count_q);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops sample the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= BCD2_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign tens = count_q.tens;
  assign ones = count_q.ones;

endmodule : bcd2_counter

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Converts the puck's per-frame hit_target / hit_floor level flags into
//   one-point-per-event BCD scores for two players, applies a serve hold-off
//   after each point, detects the winner and drives four seven-segment nibbles.
//
//   frame_clk is VGA vsync: it is synchronised into the Clk domain and only
//   its rising edge (frame_tick) is used. Hit flags are sampled on frame_tick
//   and an event is a rising edge between consecutive samples.
//
//   Parameters:
//     WIN_SCORE      points needed to win (1..99)
//     HOLDOFF_FRAMES frame ticks after a point during which hits are ignored
//     SYNC_STAGES    synchroniser depth for the three asynchronous inputs
//
//   Ports:
//     Clk           in  50 MHz system clock
//     Reset         in  asynchronous, active-high reset
//     frame_clk     in  VGA vertical sync
//     hit_target    in  level; rising edge = point to player 1
//     hit_floor     in  level; rising edge = point to player 2
//     game_active   in  high while a game screen is shown
//     clear_scores  in  single-Clk pulse: zero scores, return to IDLE
//     p1_ones/tens  out player-1 BCD digits
//     p2_ones/tens  out player-2 BCD digits
//     point_pulse   out one-Clk pulse the cycle after a point is awarded
//     winner        out 00 none, 01 player 1, 10 player 2, 11 draw
//     game_over     out high in OVER
//
//   Build option:
//     SCORE_WIN_BY_TWO_EN  when defined, a win also needs a 2-point lead;
//                          99-99 followed by another point ends as a draw.
// -----------------------------------------------------------------------------
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned HOLDOFF_FRAMES = 60,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       hit_target,
  input  logic       hit_floor,
  input  logic       game_active,
  input  logic       clear_scores,
  output logic [3:0] p1_ones,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [3:0] p2_tens,
  output logic       point_pulse,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_FRAMES);

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 0 takes the raw input, the MSB is the safe copy.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] frame_sync_q, frame_sync_d;
  logic [SYNC_STAGES-1:0] tgt_sync_q,   tgt_sync_d;
  logic [SYNC_STAGES-1:0] flr_sync_q,   flr_sync_d;

  always_comb begin
    frame_sync_d = (frame_sync_q << 1) | SYNC_STAGES'(frame_clk);
    tgt_sync_d   = (tgt_sync_q   << 1) | SYNC_STAGES'(hit_target);
    flr_sync_d   = (flr_sync_q   << 1) | SYNC_STAGES'(hit_floor);
  end

  logic frame_s, tgt_s, flr_s;
  assign frame_s = frame_sync_q[SYNC_STAGES-1];
  assign tgt_s   = tgt_sync_q[SYNC_STAGES-1];
  assign flr_s   = flr_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame tick and per-frame edge detection. The hit history advances on every
  // tick regardless of state, so a flag still high when hold-off expires is
  // already "old" and does not score.
  // ---------------------------------------------------------------------------
  logic frame_prev_q, frame_prev_d;
  logic tgt_prev_q,   tgt_prev_d;
  logic flr_prev_q,   flr_prev_d;
  logic frame_tick, evt1, evt2;

  assign frame_tick = frame_s & ~frame_prev_q;
  assign evt1       = frame_tick & tgt_s & ~tgt_prev_q;
  assign evt2       = frame_tick & flr_s & ~flr_prev_q;

  always_comb begin
    frame_prev_d = frame_s;
    tgt_prev_d   = frame_tick ? tgt_s : tgt_prev_q;
    flr_prev_d   = frame_tick ? flr_s : flr_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Score counters
  // ---------------------------------------------------------------------------
  logic  inc1, inc2, clr;
  bcd2_t p1_cur, p2_cur;
  bcd2_t p1_next, p2_next;

  bcd2_counter u_p1 (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clr),
    .inc   (inc1),
    .tens  (p1_tens),
    .ones  (p1_ones)
  );

  bcd2_counter u_p2 (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clr),
    .inc   (inc2),
    .tens  (p2_tens),
    .ones  (p2_ones)
  );

  assign p1_cur  = {p1_tens, p1_ones};
  assign p2_cur  = {p2_tens, p2_ones};
  // Post-increment values let the win decision land in the same cycle as the
  // increment, so a winning point goes straight to OVER without a hold-off.
  assign p1_next = bcd2_inc_sat(p1_cur);
  assign p2_next = bcd2_inc_sat(p2_cur);

  // ---------------------------------------------------------------------------
  // Game state machine
  // ---------------------------------------------------------------------------
  score_state_t state_q, state_d;
  logic [7:0]   hold_q,  hold_d;
  logic [1:0]   winner_q, winner_d;
  logic         pulse_q, pulse_d;

  bcd2_t       scorer_next;
  int unsigned scorer_int;
`ifdef SCORE_WIN_BY_TWO_EN
  int unsigned other_int;
  logic        both_max;
`endif

  always_comb begin
    scorer_next = evt1 ? p1_next : p2_next;
    scorer_int  = bcd2_to_int(scorer_next);
`ifdef SCORE_WIN_BY_TWO_EN
    other_int   = evt1 ? bcd2_to_int(p2_cur) : bcd2_to_int(p1_cur);
    both_max    = (p1_cur == BCD2_MAX) && (p2_cur == BCD2_MAX);
`endif
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    pulse_d  = 1'b0;
    inc1     = 1'b0;
    inc2     = 1'b0;
    clr      = 1'b0;

    if (clear_scores) begin
      // Clear outranks anything else happening this cycle, including an event.
      clr      = 1'b1;
      winner_d = WINNER_NONE;
      hold_d   = 8'd0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (game_active) state_d = PLAY;
        end

        PLAY: begin
          if (!game_active) begin
            state_d = IDLE;
          end else if (evt1 ^ evt2) begin
            // Simultaneous events are a let and fall through unchanged.
            pulse_d = 1'b1;
`ifdef SCORE_WIN_BY_TWO_EN
            if (both_max) begin
              state_d  = OVER;
              winner_d = WINNER_DRAW;
            end else begin
              inc1 = evt1;
              inc2 = evt2;
              if (scorer_int >= WIN_SCORE && scorer_int >= other_int + 32'd2) begin
                state_d  = OVER;
                winner_d = evt1 ? WINNER_P1 : WINNER_P2;
              end else begin
                hold_d  = HOLDOFF_LOAD;
                state_d = HOLD;
              end
            end
`else
            inc1 = evt1;
            inc2 = evt2;
            if (scorer_int >= WIN_SCORE) begin
              state_d  = OVER;
              winner_d = evt1 ? WINNER_P1 : WINNER_P2;
            end else begin
              hold_d  = HOLDOFF_LOAD;
              state_d = HOLD;
            end
`endif
          end
        end

        HOLD: begin
          if (!game_active) begin
            hold_d  = 8'd0;
            state_d = IDLE;
          end else if (frame_tick) begin
            if (hold_q <= 8'd1) begin
              hold_d  = 8'd0;
              state_d = PLAY;
            end else begin
              hold_d = hold_q - 8'd1;
            end
          end
        end

        OVER: begin
          // Only clear_scores or Reset leaves OVER.
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync_q <= '0;
      tgt_sync_q   <= '0;
      flr_sync_q   <= '0;
      frame_prev_q <= 1'b0;
      tgt_prev_q   <= 1'b0;
      flr_prev_q   <= 1'b0;
      state_q      <= IDLE;
      hold_q       <= 8'd0;
      winner_q     <= WINNER_NONE;
      pulse_q      <= 1'b0;
    end else begin
      frame_sync_q <= frame_sync_d;
      tgt_sync_q   <= tgt_sync_d;
      flr_sync_q   <= flr_sync_d;
      frame_prev_q <= frame_prev_d;
      tgt_prev_q   <= tgt_prev_d;
      flr_prev_q   <= flr_prev_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      winner_q     <= winner_d;
      pulse_q      <= pulse_d;
    end
  end

  assign point_pulse = pulse_q;
  assign winner      = winner_q;
  assign game_over   = (state_q == OVER);

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Self-checking bench for score_keeper. Frame-level reference model holds the
//   scores as integers and applies the game rules per frame tick.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  localparam int HOLDOFF = 3;
`ifdef SCORE_WIN_BY_TWO_EN
  localparam int WIN = 3;
`else
  localparam int WIN = 12;
`endif

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_HOLD = 2;
  localparam int S_OVER = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       hit_target;
  logic       hit_floor;
  logic       game_active;
  logic       clear_scores;
  logic [3:0] p1_ones, p1_tens, p2_ones, p2_tens;
  logic       point_pulse;
  logic [1:0] winner;
  logic       game_over;

  score_keeper #(
    .WIN_SCORE      (WIN),
    .HOLDOFF_FRAMES (HOLDOFF),
    .SYNC_STAGES    (2)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .hit_target   (hit_target),
    .hit_floor    (hit_floor),
    .game_active  (game_active),
    .clear_scores (clear_scores),
    .p1_ones      (p1_ones),
    .p1_tens      (p1_tens),
    .p2_ones      (p2_ones),
    .p2_tens      (p2_tens),
    .point_pulse  (point_pulse),
    .winner       (winner),
    .game_over    (game_over)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always @(negedge Clk) if (point_pulse === 1'b1) pulse_cnt++;

  // ---------------------------------------------------------------- model ---
  int         m_s1, m_s2, m_hold, m_state, m_pulses;
  logic [1:0] m_win;
  bit         m_pt, m_pf;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_hold = 0; m_state = S_IDLE;
    m_win = 2'b00; m_pt = 1'b0; m_pf = 1'b0;
  endtask

  task automatic model_ga(input bit ga);
    if (ga && m_state == S_IDLE) m_state = S_PLAY;
    else if (!ga && (m_state == S_PLAY || m_state == S_HOLD)) m_state = S_IDLE;
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_hold = 0; m_win = 2'b00;
    m_state = game_active ? S_PLAY : S_IDLE;
  endtask

  task automatic model_point(input bit to_p1);
    int mine, other;
    bit won;
    m_pulses++;
    mine  = to_p1 ? m_s1 : m_s2;
    other = to_p1 ? m_s2 : m_s1;
`ifdef SCORE_WIN_BY_TWO_EN
    if (m_s1 == 99 && m_s2 == 99) begin
      m_state = S_OVER;
      m_win   = 2'b11;
      return;
    end
`endif
    mine = (mine + 1 > 99) ? 99 : mine + 1;
    if (to_p1) m_s1 = mine; else m_s2 = mine;
`ifdef SCORE_WIN_BY_TWO_EN
    won = (mine >= WIN) && (mine - other >= 2);
`else
    won = (mine >= WIN);
`endif
    if (won) begin
      m_state = S_OVER;
      m_win   = to_p1 ? 2'b01 : 2'b10;
    end else begin
      m_state = S_HOLD;
      m_hold  = HOLDOFF;
    end
  endtask

  task automatic model_frame(input bit t, input bit f);
    bit e1, e2;
    e1 = t && !m_pt;
    e2 = f && !m_pf;
    m_pt = t;
    m_pf = f;
    if (m_state == S_PLAY) begin
      if (e1 != e2) model_point(e1);
    end else if (m_state == S_HOLD) begin
      m_hold--;
      if (m_hold == 0) m_state = S_PLAY;
    end
  endtask

  // --------------------------------------------------------------- checks ---
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s p1_ones", tag), 32'(p1_ones), 32'(m_s1 % 10));
    check($sformatf("%s p1_tens", tag), 32'(p1_tens), 32'(m_s1 / 10));
    check($sformatf("%s p2_ones", tag), 32'(p2_ones), 32'(m_s2 % 10));
    check($sformatf("%s p2_tens", tag), 32'(p2_tens), 32'(m_s2 / 10));
    check($sformatf("%s winner", tag), 32'(winner), 32'(m_win));
    check($sformatf("%s game_over", tag), 32'(game_over), 32'(m_state == S_OVER));
    check($sformatf("%s pulses", tag), 32'(pulse_cnt), 32'(m_pulses));
  endtask

  // -------------------------------------------------------------- drivers ---
  task automatic frame(input bit t, input bit f);
    @(negedge Clk);
    hit_target = t;
    hit_floor  = f;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    model_frame(t, f);
  endtask

  // clear_scores lands in the same Clk cycle as the frame tick (2-stage sync).
  task automatic frame_clear(input bit t, input bit f);
    @(negedge Clk);
    hit_target = t;
    hit_floor  = f;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    clear_scores = 1'b1;
    @(negedge Clk);
    clear_scores = 1'b0;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    m_pt = t;
    m_pf = f;
    model_clear();
  endtask

  task automatic point(input bit to_p1);
    frame(to_p1, !to_p1);
    repeat (HOLDOFF) frame(1'b0, 1'b0);
  endtask

  task automatic set_ga(input bit v);
    @(negedge Clk);
    game_active = v;
    model_ga(v);
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    clear_scores = 1'b1;
    @(negedge Clk);
    clear_scores = 1'b0;
    model_clear();
    @(negedge Clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------------- test ---
  typedef struct {
    bit t;
    bit f;
    int p1;
    int p2;
    int pulses;
  } vec_t;

  vec_t vecs [21];

  initial begin
    // held flag, hold-off masking, let, and let not loading a hold-off
    vecs = '{
      '{1'b1, 1'b0, 1, 0, 1}, '{1'b1, 1'b0, 1, 0, 1}, '{1'b1, 1'b0, 1, 0, 1},
      '{1'b1, 1'b0, 1, 0, 1}, '{1'b1, 1'b0, 1, 0, 1}, '{1'b0, 1'b0, 1, 0, 1},
      '{1'b1, 1'b0, 2, 0, 2}, '{1'b0, 1'b1, 2, 0, 2}, '{1'b0, 1'b1, 2, 0, 2},
      '{1'b0, 1'b0, 2, 0, 2}, '{1'b0, 1'b0, 2, 0, 2}, '{1'b0, 1'b1, 2, 1, 3},
      '{1'b0, 1'b0, 2, 1, 3}, '{1'b0, 1'b0, 2, 1, 3}, '{1'b0, 1'b0, 2, 1, 3},
      '{1'b1, 1'b1, 2, 1, 3}, '{1'b0, 1'b0, 2, 1, 3}, '{1'b1, 1'b0, 3, 1, 4},
      '{1'b0, 1'b0, 3, 1, 4}, '{1'b0, 1'b0, 3, 1, 4}, '{1'b0, 1'b0, 3, 1, 4}
    };

    Reset = 1'b1;
    frame_clk = 1'b0; hit_target = 1'b0; hit_floor = 1'b0;
    game_active = 1'b0; clear_scores = 1'b0;
    model_reset();
    m_pulses = 0;
    repeat (3) @(negedge Clk);
    check_all("reset");
    check("reset point_pulse", 32'(point_pulse), 32'd0);
    Reset = 1'b0;
    set_ga(1'b1);

    // Table-driven scenario
    for (int i = 0; i < 21; i++) begin
      frame(vecs[i].t, vecs[i].f);
`ifndef SCORE_WIN_BY_TWO_EN
      check($sformatf("vec%0d p1", i), 32'(p1_tens) * 10 + 32'(p1_ones), 32'(vecs[i].p1));
      check($sformatf("vec%0d p2", i), 32'(p2_tens) * 10 + 32'(p2_ones), 32'(vecs[i].p2));
      check($sformatf("vec%0d pulses", i), 32'(pulse_cnt), 32'(vecs[i].pulses));
      check($sformatf("vec%0d game_over", i), 32'(game_over), 32'd0);
`endif
      check_all($sformatf("vec%0d", i));
    end

    pulse_clear();
    check_all("clear");

`ifdef SCORE_WIN_BY_TWO_EN
    // Win-by-two: 3-3, then 3-4 does not win, 3-5 does
    point(1'b1); point(1'b0); point(1'b1); point(1'b0); point(1'b1);
    check_all("wbt 3-2");
    check("wbt 3-2 game_over", 32'(game_over), 32'd0);
    point(1'b0);
    check_all("wbt 3-3");
    point(1'b0);
    check("wbt 3-4 p2_ones", 32'(p2_ones), 32'd4);
    check("wbt 3-4 winner", 32'(winner), 32'd0);
    check("wbt 3-4 game_over", 32'(game_over), 32'd0);
    point(1'b0);
    check("wbt 3-5 p2_ones", 32'(p2_ones), 32'd5);
    check("wbt 3-5 winner", 32'(winner), 32'b10);
    check("wbt 3-5 game_over", 32'(game_over), 32'd1);
    check_all("wbt 3-5");
`else
    // Twelve separated player-1 points against WIN=12
    for (int i = 1; i <= 12; i++) begin
      point(1'b1);
      if (i == 10) begin
        check("ten p1_tens", 32'(p1_tens), 32'd1);
        check("ten p1_ones", 32'(p1_ones), 32'd0);
        check("ten game_over", 32'(game_over), 32'd0);
      end
    end
    check("twelve game_over", 32'(game_over), 32'd1);
    check("twelve winner", 32'(winner), 32'b01);
    check("twelve p1_ones", 32'(p1_ones), 32'd2);
    check_all("twelve");
    frame(1'b1, 1'b0); frame(1'b0, 1'b0); frame(1'b0, 1'b1);
    check("over p1_ones", 32'(p1_ones), 32'd2);
    check("over p2_ones", 32'(p2_ones), 32'd0);
    check("over pulses", 32'(pulse_cnt), 32'd16);
    frame(1'b0, 1'b0);
    check_all("over hold");
`endif

    // Clear in OVER on the same cycle as an event, game screen gone
    set_ga(1'b0);
    frame_clear(1'b0, 1'b1);
    check("clr p1_ones", 32'(p1_ones), 32'd0);
    check("clr p1_tens", 32'(p1_tens), 32'd0);
    check("clr p2_ones", 32'(p2_ones), 32'd0);
    check("clr winner", 32'(winner), 32'd0);
    check("clr game_over", 32'(game_over), 32'd0);
    check_all("clr");
    // IDLE ignores a fresh rising edge
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    check_all("idle ignore");
    set_ga(1'b1);
    frame(1'b0, 1'b0);

    // Asynchronous reset in the middle of a hold-off
    frame(1'b1, 1'b0);
    check_all("pre reset");
    @(negedge Clk);
    hit_target = 1'b0;
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    check_all("async reset");
    @(negedge Clk);
    Reset = 1'b0;
    model_ga(game_active);
    repeat (2) @(negedge Clk);

    // Randomized frames against the model
    for (int n = 0; n < 200; n++) begin
      int r;
      bit t, f;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        pulse_clear();
      end else if (r < 9) begin
        set_ga(!game_active);
      end
      t = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 2) == 0);
      frame(t, f);
      check_all($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_score_keeper
